// File: rtl/cp_phase_sched_pkg.sv
// Shared types and default constants for the emulated-clock phase scheduler.
package cp_phase_sched_pkg;

    localparam int unsigned PHASES_DEF     = 4;
    localparam int unsigned DIV_W_DEF      = 4;
    localparam int unsigned CLR_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2,
        STEP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/cp_phase_sched_if.sv
// Control inputs and cell strobe outputs between system top level and scheduler.
interface cp_phase_sched_if
    import cp_phase_sched_pkg::*;
#(
    parameter int unsigned PHASES = PHASES_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
);
    logic              run;
    logic              step_req;
    logic              clr_req;
    logic [DIV_W-1:0]  div;
    logic [PHASES-1:0] cp;
    logic              cd;
    logic              frame;
    logic              step_ack;
    logic              running;

    modport master (
        output run, step_req, clr_req, div,
        input  cp, cd, frame, step_ack, running
    );

    modport slave (
        input  run, step_req, clr_req, div,
        output cp, cd, frame, step_ack, running
    );
endinterface

// File: rtl/cp_slot_ctr.sv
// Slot/phase position within an emulated-clock frame, plus next-cycle lookahead
// so the scheduler can register its strobes.
module cp_slot_ctr #(
    parameter int unsigned PHASES = 4,
    parameter int unsigned DIV_W  = 4,
    parameter int unsigned PH_W   = 2
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             frame_end_c,
    output logic             slot_start_c,
    output logic             last_next_c,
    output logic [PH_W-1:0]  phase_c
);

    logic [DIV_W-1:0] slot_q, slot_n, div_q, div_n, div_eff;
    logic [PH_W-1:0]  phase_q, phase_n;
    logic             first, slot_end;

    // The divide is taken live on a frame's first cycle and held for the rest of it.
    always_comb begin
        first        = (slot_q == '0) && (phase_q == '0);
        div_eff      = first ? div : div_q;
        slot_end     = (slot_q == div_eff);
        frame_end_c  = slot_end && (phase_q == PH_W'(PHASES - 1));
        div_n        = div_eff;
        slot_n       = slot_q + DIV_W'(1);
        phase_n      = phase_q;
        if (slot_end) begin
            slot_n  = '0;
            phase_n = frame_end_c ? '0 : phase_q + PH_W'(1);
        end
        if (hold) begin
            slot_n  = '0;
            phase_n = '0;
        end
        slot_start_c = (slot_n == '0);
        last_next_c  = (phase_n == PH_W'(PHASES - 1)) && (slot_n == div_n);
        phase_c      = phase_n;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            slot_q  <= '0;
            phase_q <= '0;
            div_q   <= '0;
        end else begin
            slot_q  <= slot_n;
            phase_q <= phase_n;
            div_q   <= div_n;
        end
    end

endmodule

// File: rtl/cp_phase_sched.sv
// Emulated-clock sequencer: clear, free-run, halt on frame boundary and
// single-frame step, driving the cells' cp enables and cd clear.
module cp_phase_sched
    import cp_phase_sched_pkg::*;
#(
    parameter int unsigned PHASES     = PHASES_DEF,
    parameter int unsigned DIV_W      = DIV_W_DEF,
    parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF
) (
    input  logic           sys_clk,
    input  logic           reset,
    cp_phase_sched_if.slave bus
);

    localparam int unsigned PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int unsigned CNT_W = $clog2(CLR_CYCLES + 1);

    sched_state_e      state_q, state_n;
    logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_n;
    logic [PHASES-1:0] cp_q, cp_n;
    logic              cd_q, cd_n, frame_q, frame_n, ack_q, ack_n, running_q, running_n;
    logic              cnt_hold, frame_end, slot_start, last_next;
    logic [PH_W-1:0]   phase_nxt;

    cp_slot_ctr #(
        .PHASES (PHASES),
        .DIV_W  (DIV_W),
        .PH_W   (PH_W)
    ) u_slot_ctr (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .hold         (cnt_hold),
        .div          (bus.div),
        .frame_end_c  (frame_end),
        .slot_start_c (slot_start),
        .last_next_c  (last_next),
        .phase_c      (phase_nxt)
    );

    // Next state, then outputs for the coming cycle from the counter lookahead.
    always_comb begin
        state_n   = state_q;
        clr_cnt_n = clr_cnt_q;
        ack_n     = ack_q;
        if (ack_q && !bus.step_req) ack_n = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
                    state_n   = IDLE;
                    clr_cnt_n = '0;
                end else begin
                    clr_cnt_n = clr_cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (bus.run)                      state_n = RUN;
                else if (bus.step_req && !ack_q)  state_n = STEP;
            end
            RUN: begin
                if (frame_end && !bus.run) state_n = IDLE;
            end
            STEP: begin
                if (frame_end) begin
                    state_n = IDLE;
                    ack_n   = 1'b1;
                end
            end
            default: state_n = CLEAR;
        endcase
        if (bus.clr_req) begin
            state_n   = CLEAR;
            clr_cnt_n = '0;
            ack_n     = 1'b0;
        end

        cnt_hold  = !((state_q == RUN) || (state_q == STEP)) || bus.clr_req;
        running_n = (state_n == RUN) || (state_n == STEP);
        cp_n      = (running_n && slot_start) ? (PHASES'(1) << phase_nxt) : '0;
        frame_n   = running_n && last_next;
        cd_n      = (state_n != CLEAR);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            cp_q      <= '0;
            cd_q      <= 1'b0;
            frame_q   <= 1'b0;
            ack_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            clr_cnt_q <= clr_cnt_n;
            cp_q      <= cp_n;
            cd_q      <= cd_n;
            frame_q   <= frame_n;
            ack_q     <= ack_n;
            running_q <= running_n;
        end
    end

    assign bus.cp       = cp_q;
    assign bus.cd       = cd_q;
    assign bus.frame    = frame_q;
    assign bus.step_ack = ack_q;
    assign bus.running  = running_q;

endmodule

// File: tb/tb_cp_phase_sched.sv
// Bench for cp_phase_sched: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized control traffic.
module tb_cp_phase_sched;
    import cp_phase_sched_pkg::*;

    localparam int unsigned P   = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned CLR = 8;

    localparam int M_CLR = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    cp_phase_sched_if #(.PHASES(P), .DIV_W(DW)) bus ();

    cp_phase_sched #(
        .PHASES     (P),
        .DIV_W      (DW),
        .CLR_CYCLES (CLR)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: mode, cycles left in clear, cycle index k inside the frame, latched divide.
    int m_mode = M_CLR, m_cnt = 0, m_k = 0, m_d = 0;
    bit m_ack = 1'b0;

    function automatic logic [P-1:0] exp_cp();
        int slot_len;
        if (!(m_mode == M_RUN || m_mode == M_STEP)) return '0;
        if (m_k == 0) return P'(1);
        slot_len = m_d + 1;
        if (m_k % slot_len == 0) return P'(1) << (m_k / slot_len);
        return '0;
    endfunction

    function automatic bit exp_frame();
        if (!(m_mode == M_RUN || m_mode == M_STEP)) return 1'b0;
        return (m_k != 0) && (m_k == int'(P) * (m_d + 1) - 1);
    endfunction

    task automatic model_step(input bit r, input bit s, input bit c, input int dv);
        bit last;
        bit old_ack;
        old_ack = m_ack;
        if (c) begin
            m_mode = M_CLR; m_cnt = 0; m_k = 0; m_ack = 1'b0;
            return;
        end
        if (m_ack && !s) m_ack = 1'b0;
        case (m_mode)
            M_CLR: begin
                m_cnt++;
                if (m_cnt == int'(CLR)) begin m_mode = M_IDLE; m_cnt = 0; end
            end
            M_IDLE: begin
                if (r)                  begin m_mode = M_RUN;  m_k = 0; end
                else if (s && !old_ack) begin m_mode = M_STEP; m_k = 0; end
            end
            default: begin
                if (m_k == 0) m_d = dv;
                last = (m_k == int'(P) * (m_d + 1) - 1);
                m_k++;
                if (last) begin
                    m_k = 0;
                    if (m_mode == M_STEP) begin m_mode = M_IDLE; m_ack = 1'b1; end
                    else if (!r)          m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge sys_clk);
        if (reset) begin
            m_mode = M_CLR; m_cnt = 0; m_k = 0; m_d = 0; m_ack = 1'b0;
        end else begin
            model_step(bus.run, bus.step_req, bus.clr_req, int'(bus.div));
        end
    end

    initial forever begin
        @(negedge sys_clk);
        if (!reset) begin
            chk("m_cp",       32'(bus.cp),       32'(exp_cp()));
            chk("m_cd",       32'(bus.cd),       32'(m_mode != M_CLR));
            chk("m_frame",    32'(bus.frame),    32'(exp_frame()));
            chk("m_step_ack", 32'(bus.step_ack), 32'(m_ack));
            chk("m_running",  32'(bus.running),  32'(m_mode == M_RUN || m_mode == M_STEP));
            chk("cp_onehot0", 32'($onehot0(bus.cp)), 32'd1);
            chk("cp_during_clear", 32'((bus.cp != '0) && !bus.cd), 32'd0);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        bus.run = 1'b0;
        while (bus.running && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    logic [P-1:0] seq [8];
    int n_low, n_cp;

    initial begin
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bus.run = 1'b0; bus.step_req = 1'b0; bus.clr_req = 1'b0; bus.div = '0;

        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_outputs", 32'({bus.cp, bus.cd, bus.frame, bus.step_ack, bus.running}), 32'd0);
        @(posedge sys_clk);
        #1 reset = 1'b0;

        // Power-on clear length.
        n_low = 0; n_cp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (!bus.cd) n_low++;
            if (bus.cp != '0) n_cp++;
        end
        chk("clr_len", 32'(n_low), 32'd8);
        chk("clr_no_cp", 32'(n_cp), 32'd0);
        chk("idle_running", 32'(bus.running), 32'd0);

        // div = 0 free run.
        bus.div = '0; bus.run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            chk("div0_seq", 32'(bus.cp), 32'(seq[i]));
            chk("div0_frame", 32'(bus.frame), 32'(i % 4 == 3));
        end
        wait_idle();

        // div = 2, then change to 0 mid-frame.
        bus.div = DW'(2); bus.run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            case (i)
                3:  chk("div2_cp1",      32'(bus.cp), 32'h2);
                9:  chk("div2_cp3",      32'(bus.cp), 32'h8);
                11: chk("div2_frame",    32'(bus.frame), 32'd1);
                15: chk("div_held_cp1",  32'(bus.cp), 32'h2);
                24: chk("div_new_cp0",   32'(bus.cp), 32'h1);
                25: chk("div_new_cp1",   32'(bus.cp), 32'h2);
                27: chk("div_new_frame", 32'(bus.frame), 32'd1);
                default: ;
            endcase
            if (i == 13) bus.div = '0;
        end
        wait_idle();

        // run dropped in slot 1 still completes the frame.
        bus.div = DW'(1); bus.run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk);
            case (i)
                4: chk("drop_cp2",   32'(bus.cp), 32'h4);
                6: chk("drop_cp3",   32'(bus.cp), 32'h8);
                7: chk("drop_frame", 32'(bus.frame), 32'd1);
                8: chk("drop_idle",  32'({bus.running, bus.cp}), 32'd0);
                default: ;
            endcase
            if (i == 2) bus.run = 1'b0;
        end

        // Single step with handshake.
        bus.step_req = 1'b1;
        n_cp = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            if (i < 8 && bus.cp != '0) n_cp++;
            if (i == 7) chk("step_strobes", 32'(n_cp), 32'd4);
            if (i == 8) begin
                chk("step_ack_rise", 32'(bus.step_ack), 32'd1);
                n_cp = 0;
            end
            if (i > 8 && bus.cp != '0) n_cp++;
            if (i == 14) begin
                chk("step_no_second", 32'(n_cp), 32'd0);
                chk("step_ack_held", 32'(bus.step_ack), 32'd1);
                bus.step_req = 1'b0;
            end
            if (i == 15) chk("step_ack_drop", 32'(bus.step_ack), 32'd0);
        end

        // Soft clear during slot 2 of a run, run held high.
        bus.div = '0; bus.run = 1'b1;
        n_low = 0; n_cp = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge sys_clk);
            if (i >= 3 && i <= 11) begin
                if (!bus.cd) n_low++;
                if (bus.cp != '0) n_cp++;
            end
            if (i == 12) begin
                chk("clr_req_len", 32'(n_low), 32'd8);
                chk("clr_req_no_cp", 32'(n_cp), 32'd0);
                chk("clr_resume_cp0", 32'(bus.cp), 32'h1);
            end
            bus.clr_req = (i == 2);
        end

        // Randomized control traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            bus.clr_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
            if (!bus.step_req && !bus.step_ack && $urandom_range(0, 7) == 0)
                bus.step_req = 1'b1;
            else if (bus.step_req && bus.step_ack && $urandom_range(0, 3) == 0)
                bus.step_req = 1'b0;
            if ($urandom_range(0, 15) == 0)
                bus.div = DW'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 15 : 3));
        end
        bus.clr_req = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
